// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned FUNCT_W = 3;
  localparam logic [FUNCT_W-1:0] FUNCT_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic               ls_req;
  logic               ls_we;
  logic [FUNCT_W-1:0] ls_funct;
  logic [ADDR_W-1:0]  ls_addr;
  logic [DATA_W-1:0]  ls_wdata;
  logic               ls_gnt;
  logic               ls_done;
  logic [DATA_W-1:0]  ls_rdata;

  logic               mem_req;
  logic               mem_we;
  logic [FUNCT_W-1:0] mem_funct;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ack;
  logic [DATA_W-1:0]  mem_rdata;

  logic busy;
  logic err_spurious;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_funct, ls_addr, ls_wdata,
    output ls_gnt, ls_done, ls_rdata,
    output mem_req, mem_we, mem_funct, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy, err_spurious
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_funct, ls_addr, ls_wdata,
    input  ls_gnt, ls_done, ls_rdata,
    input  mem_req, mem_we, mem_funct, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy, err_spurious
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts load/store wins over a waiting fetch; at_limit hands the next contested grant to fetch.
module mem_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_if,
  input  logic grant_ls,
  input  logic if_req,
  output logic at_limit
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Saturating increment when fetch loses; any fetch grant or uncontested grant clears.
  always_comb begin
    cnt_nxt = cnt;
    if (grant_if || (grant_ls && !if_req)) begin
      cnt_nxt = '0;
    end else if (grant_ls && (cnt != CNT_W'(LIMIT))) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Count and its limit flag are both held in flops so the grant path sees a registered bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      at_limit <= (LIMIT == 0);
    end else begin
      cnt      <= cnt_nxt;
      at_limit <= (cnt_nxt == CNT_W'(LIMIT));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one blocking memory port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e state;
  owner_e     gnt_owner;
  logic       gnt_any;
  logic       grant_if;
  logic       grant_ls;
  logic       starve_hit;

  logic               mem_req_q;
  logic               mem_we_q;
  logic [FUNCT_W-1:0] mem_funct_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               busy_q;
  logic               if_rvalid_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic               ls_done_q;
  logic [DATA_W-1:0]  ls_rdata_q;
  logic               err_q;

  // Same-cycle grant decision: load/store wins unless fetch has been starved long enough.
  always_comb begin
    gnt_any   = (state == ST_IDLE) && (bus.if_req || bus.ls_req);
    gnt_owner = OWNER_LS;
    if (bus.if_req && (!bus.ls_req || starve_hit)) begin
      gnt_owner = OWNER_IF;
    end
    grant_if = gnt_any && (gnt_owner == OWNER_IF);
    grant_ls = gnt_any && (gnt_owner == OWNER_LS);
  end

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .grant_if (grant_if),
    .grant_ls (grant_ls),
    .if_req   (bus.if_req),
    .at_limit (starve_hit)
  );

  // Arbiter FSM: latch the granted payload, hold the port until ack, return data one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_funct_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_done_q   <= 1'b0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_done_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.mem_ack) begin
            err_q <= 1'b1;
          end
          if (gnt_any) begin
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            if (gnt_owner == OWNER_IF) begin
              mem_we_q    <= 1'b0;
              mem_funct_q <= FUNCT_WORD;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
              state       <= ST_BUSY_IF;
            end else begin
              mem_we_q    <= bus.ls_we;
              mem_funct_q <= bus.ls_funct;
              mem_addr_q  <= bus.ls_addr;
              mem_wdata_q <= bus.ls_wdata;
              state       <= ST_BUSY_LS;
            end
          end
        end
        ST_BUSY_IF: begin
          if (bus.mem_ack) begin
            if_rdata_q  <= bus.mem_rdata;
            if_rvalid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_BUSY_LS: begin
          if (bus.mem_ack) begin
            // Stores leave the previous load result visible.
            if (!mem_we_q) begin
              ls_rdata_q <= bus.mem_rdata;
            end
            ls_done_q <= 1'b1;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt       = grant_if;
  assign bus.ls_gnt       = grant_ls;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_funct    = mem_funct_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.busy         = busy_q;
  assign bus.if_rvalid    = if_rvalid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.ls_done      = ls_done_q;
  assign bus.ls_rdata     = ls_rdata_q;
  assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_if;
    logic        we;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: memory contents, starvation count, expected traffic.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rsp_mem [logic [31:0]];
  txn_t        exp_mem_q [$];
  logic [31:0] exp_if_q [$];
  logic [31:0] exp_ls_q [$];
  int          starve = 0;
  bit          outstanding = 0;
  bit          first_busy = 0;
  int          wait_left = 0;
  logic [31:0] ls_last_model = '0;
  bit          exp_err = 0;
  int          if_due = -1;
  int          ls_due = -1;
  txn_t        cur;

  // Requester state and knobs.
  bit          if_pend = 0;
  bit          ls_pend = 0;
  logic [31:0] if_a = '0;
  txn_t        ls_t;
  logic [31:0] if_todo [$];
  txn_t        ls_todo [$];
  int          p_if = 0;
  int          p_ls = 0;
  int          wait_min = 0;
  int          wait_max = 0;
  bit          loads_only = 0;
  bit          spur_now = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] rsp_rd(input logic [31:0] a);
    return rsp_mem.exists(a) ? rsp_mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h0000_1000 + (32'($urandom_range(15, 0)) << 2);
  endfunction

  // One clock cycle of requesters, memory responder and model; entered and left at negedge.
  task automatic step();
    bit          ack;
    bit          spur_ack;
    bit          exp_gi;
    bit          exp_gl;
    logic [31:0] rd;
    logic [31:0] d;

    if (!if_pend) begin
      if (if_todo.size() > 0) begin
        if_a = if_todo.pop_front();
        if_pend = 1;
      end else if (int'($urandom_range(99, 0)) < p_if) begin
        if_a = rnd_addr();
        if_pend = 1;
      end
    end
    if (!ls_pend) begin
      if (ls_todo.size() > 0) begin
        ls_t = ls_todo.pop_front();
        ls_pend = 1;
      end else if (int'($urandom_range(99, 0)) < p_ls) begin
        ls_t.is_if = 1'b0;
        ls_t.we    = loads_only ? 1'b0 : 1'($urandom_range(1, 0));
        ls_t.funct = 3'($urandom_range(7, 0));
        ls_t.addr  = rnd_addr();
        ls_t.wdata = $urandom;
        ls_pend = 1;
      end
    end
    bus.if_req   = if_pend;
    bus.if_addr  = if_a;
    bus.ls_req   = ls_pend;
    bus.ls_we    = ls_t.we;
    bus.ls_funct = ls_t.funct;
    bus.ls_addr  = ls_t.addr;
    bus.ls_wdata = ls_t.wdata;

    // Memory responder: checks the presented access, then acks after the chosen wait.
    ack = 0;
    spur_ack = 0;
    rd = $urandom;
    if (outstanding) begin
      check("mem_req_busy", 32'(bus.mem_req), 32'd1);
      check("busy_busy", 32'(bus.busy), 32'd1);
      if (first_busy) begin
        first_busy = 0;
        if (exp_mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_access: got unexpected access expected none (cycle %0d)", cyc);
        end else begin
          cur = exp_mem_q.pop_front();
          check("mem_we", 32'(bus.mem_we), 32'(cur.we));
          check("mem_funct", 32'(bus.mem_funct), 32'(cur.funct));
          check("mem_addr", bus.mem_addr, cur.addr);
          if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
        end
      end
      if (wait_left == 0) begin
        ack = 1;
        if (cur.we) rsp_mem[cur.addr] = cur.wdata;
        else rd = rsp_rd(cur.addr);
        if (cur.is_if) if_due = cyc + 1;
        else ls_due = cyc + 1;
      end else begin
        wait_left--;
      end
    end else begin
      check("mem_req_idle", 32'(bus.mem_req), 32'd0);
      check("busy_idle", 32'(bus.busy), 32'd0);
      ack = spur_now;
      spur_ack = spur_now;
      spur_now = 0;
    end
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;

    #1;
    exp_gi = !outstanding && if_pend && (!ls_pend || starve == int'(STARVE_LIMIT));
    exp_gl = !outstanding && ls_pend && !exp_gi;
    check("if_gnt", 32'(bus.if_gnt), 32'(exp_gi));
    check("ls_gnt", 32'(bus.ls_gnt), 32'(exp_gl));

    if (exp_gi) begin
      starve = 0;
      exp_mem_q.push_back('{is_if: 1'b1, we: 1'b0, funct: FUNCT_WORD, addr: if_a, wdata: 32'h0});
      exp_if_q.push_back(ref_rd(if_a));
      if_pend = 0;
    end
    if (exp_gl) begin
      starve = if_pend ? ((starve < int'(STARVE_LIMIT)) ? starve + 1 : starve) : 0;
      exp_mem_q.push_back(ls_t);
      if (ls_t.we) begin
        ref_mem[ls_t.addr] = ls_t.wdata;
        exp_ls_q.push_back(ls_last_model);
      end else begin
        d = ref_rd(ls_t.addr);
        ls_last_model = d;
        exp_ls_q.push_back(d);
      end
      ls_pend = 0;
    end

    @(posedge clk);
    #1;
    if (exp_gi || exp_gl) begin
      outstanding = 1;
      first_busy = 1;
      wait_left = int'($urandom_range(wait_max, wait_min));
    end else if (ack && outstanding) begin
      outstanding = 0;
    end
    if (spur_ack) exp_err = 1;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    p_if = 0;
    p_ls = 0;
    run(16);
  endtask

  // Monitor: pops expected completions on each pulse and checks hold/sticky behaviour.
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_if = '0;
        last_ls = '0;
      end else begin
        check("if_rvalid", 32'(bus.if_rvalid), 32'(cyc == if_due));
        if (bus.if_rvalid) begin
          if (exp_if_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL if_rdata: got pulse expected none (cycle %0d)", cyc);
          end else begin
            e = exp_if_q.pop_front();
            check("if_rdata", bus.if_rdata, e);
            last_if = e;
          end
        end else begin
          check("if_rdata_hold", bus.if_rdata, last_if);
        end
        check("ls_done", 32'(bus.ls_done), 32'(cyc == ls_due));
        if (bus.ls_done) begin
          if (exp_ls_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ls_rdata: got pulse expected none (cycle %0d)", cyc);
          end else begin
            e = exp_ls_q.pop_front();
            check("ls_rdata", bus.ls_rdata, e);
            last_ls = e;
          end
        end else begin
          check("ls_rdata_hold", bus.ls_rdata, last_ls);
        end
        check("err_spurious", 32'(bus.err_spurious), 32'(exp_err));
      end
    end
  end

  initial begin
    ls_t = '0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_funct = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    // Reset values.
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_funct", 32'(bus.mem_funct), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_ls_rdata", bus.ls_rdata, 32'd0);
    check("rst_err", 32'(bus.err_spurious), 32'd0);
    #2 reset = 0;
    @(negedge clk);

    // Single fetch with three-cycle ack.
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    rsp_mem[32'h100] = 32'hDEAD_BEEF;
    wait_min = 2; wait_max = 2;
    if_todo.push_back(32'h100);
    run(6);

    // Simultaneous fetch and store: store first.
    wait_min = 1; wait_max = 1;
    if_todo.push_back(32'h104);
    ls_todo.push_back('{is_if: 1'b0, we: 1'b1, funct: 3'b000, addr: 32'h200, wdata: 32'h55});
    run(10);

    // Both held continuously with single-cycle acks: starvation rotation.
    wait_min = 0; wait_max = 0;
    p_if = 100; p_ls = 100;
    run(40);
    drain();

    // Spurious ack while idle.
    spur_now = 1;
    run(4);

    // Zero-wait back-to-back loads.
    loads_only = 1;
    p_ls = 100;
    run(20);
    loads_only = 0;
    drain();

    // Random traffic with variable memory latency.
    wait_min = 0; wait_max = 3;
    p_if = 40; p_ls = 40;
    run(1500);
    drain();

    // Reset while a load is waiting for its ack.
    wait_min = 50; wait_max = 50;
    ls_todo.push_back('{is_if: 1'b0, we: 1'b0, funct: 3'b010, addr: 32'h40, wdata: 32'h0});
    run(3);
    #2 reset = 1;
    #1;
    check("rst_flight_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_flight_busy", 32'(bus.busy), 32'd0);
    outstanding = 0;
    first_busy = 0;
    starve = 0;
    if (exp_ls_q.size() > 0) void'(exp_ls_q.pop_back());
    ls_last_model = '0;
    exp_err = 0;
    ls_pend = 0;
    if_pend = 0;
    bus.ls_req = 0;
    bus.mem_ack = 0;
    // Grant stays combinational during reset but nothing is latched.
    bus.if_req = 1;
    bus.if_addr = 32'h300;
    #1;
    check("rst_if_gnt_comb", 32'(bus.if_gnt), 32'd1);
    @(posedge clk);
    #1;
    check("rst_no_latch", 32'(bus.mem_req), 32'd0);
    bus.if_req = 0;
    @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    wait_min = 0; wait_max = 3;
    p_if = 50; p_ls = 50;
    run(200);
    drain();

    check("if_q_left", 32'(exp_if_q.size()), 32'd0);
    check("ls_q_left", 32'(exp_ls_q.size()), 32'd0);
    check("mem_q_left", 32'(exp_mem_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by 500000");
    $fatal(1, "timeout");
  end

endmodule
